// File: rtl/risc_pkg.sv
// Shared core types: memory access size plus the state and owner encodings
// used by the unified-memory port arbiter.
package risc_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_D
  } arb_owner_t;

  localparam int STREAK_W = 4;
  typedef logic [STREAK_W-1:0] streak_t;

  // Increment that stops at the forcing limit; the counter never needs to exceed it.
  function automatic streak_t streak_inc(input streak_t s, input streak_t limit);
    return (s >= limit) ? limit : s + streak_t'(1);
  endfunction

endpackage

// File: rtl/arb_grant_select.sv
// Combinational winner pick for the memory port: D has priority unless it has
// already won MAX_D_STREAK times in a row while fetch was waiting.
module arb_grant_select
  import risc_pkg::*;
#(
  parameter int MAX_D_STREAK = 4
) (
  input  logic       i_valid,
  input  logic       d_valid,
  input  streak_t    streak,
  output arb_owner_t owner
);

  always_comb begin
    // NOTE: default assignment first so no path through the block leaves owner unassigned (no latch).
    owner = OWN_NONE;
    if (i_valid && d_valid) begin
      owner = (streak == streak_t'(MAX_D_STREAK)) ? OWN_I : OWN_D;
    end else if (i_valid) begin
      owner = OWN_I;
    end else if (d_valid) begin
      owner = OWN_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch (I) and load/store (D): one
// transaction outstanding, response routed back to the owning requester.
module mem_port_arbiter
  import risc_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_rsp_valid,
  output logic [DATA_W-1:0] i_rsp_data,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_wr_en,
  input  mem_size_t         d_size,
  input  logic              d_zero_extend,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rsp_data,
  output logic              m_req_valid,
  input  logic              m_req_ready,
  output logic              m_wr_en,
  output mem_size_t         m_size,
  output logic              m_zero_extend,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wr_data,
  input  logic              m_rsp_valid,
  input  logic [DATA_W-1:0] m_rsp_data
);

  arb_state_t        state_q, state_d;
  arb_owner_t        owner_q, owner_d;
  streak_t           streak_q, streak_d;
  logic              i_req_ready_q, i_req_ready_d;
  logic              d_req_ready_q, d_req_ready_d;
  logic              i_rsp_valid_q, i_rsp_valid_d;
  logic              d_rsp_valid_q, d_rsp_valid_d;
  logic [DATA_W-1:0] i_rsp_data_q, i_rsp_data_d;
  logic [DATA_W-1:0] d_rsp_data_q, d_rsp_data_d;
  logic              m_req_valid_q, m_req_valid_d;
  logic              m_wr_en_q, m_wr_en_d;
  mem_size_t         m_size_q, m_size_d;
  logic              m_zero_extend_q, m_zero_extend_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wr_data_q, m_wr_data_d;
  arb_owner_t        pick;

  arb_grant_select #(.MAX_D_STREAK(MAX_D_STREAK)) u_grant_select (
    .i_valid (i_req_valid),
    .d_valid (d_req_valid),
    .streak  (streak_q),
    .owner   (pick)
  );

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    streak_d        = streak_q;
    i_req_ready_d   = 1'b0;
    d_req_ready_d   = 1'b0;
    i_rsp_valid_d   = 1'b0;
    d_rsp_valid_d   = 1'b0;
    i_rsp_data_d    = i_rsp_data_q;
    d_rsp_data_d    = d_rsp_data_q;
    m_req_valid_d   = m_req_valid_q;
    m_wr_en_d       = m_wr_en_q;
    m_size_d        = m_size_q;
    m_zero_extend_d = m_zero_extend_q;
    m_addr_d        = m_addr_q;
    m_wr_data_d     = m_wr_data_q;

    unique case (state_q)
      ARB_IDLE: begin
        if (owner_q == OWN_NONE) begin
          // Arbitrate; the ready pulse and latched fields appear next cycle.
          if (pick == OWN_I) begin
            owner_d         = OWN_I;
            i_req_ready_d   = 1'b1;
            m_wr_en_d       = 1'b0;
            m_size_d        = MEM_WORD;
            m_zero_extend_d = 1'b0;
            m_addr_d        = i_addr;
            m_wr_data_d     = '0;
            streak_d        = '0;
          end else if (pick == OWN_D) begin
            owner_d         = OWN_D;
            d_req_ready_d   = 1'b1;
            m_wr_en_d       = d_wr_en;
            m_size_d        = d_size;
            m_zero_extend_d = d_zero_extend;
            m_addr_d        = d_addr;
            m_wr_data_d     = d_wr_data;
            streak_d        = i_req_valid ? streak_inc(streak_q, streak_t'(MAX_D_STREAK)) : '0;
          end
        end else begin
          state_d       = ARB_ISSUE;
          m_req_valid_d = 1'b1;
        end
      end
      ARB_ISSUE: begin
        if (m_req_ready) begin
          state_d       = ARB_WAIT;
          m_req_valid_d = 1'b0;
        end
      end
      ARB_WAIT: begin
        if (m_rsp_valid) begin
          if (owner_q == OWN_I) begin
            i_rsp_valid_d = 1'b1;
            i_rsp_data_d  = m_rsp_data;
          end else if (owner_q == OWN_D) begin
            d_rsp_valid_d = 1'b1;
            d_rsp_data_d  = m_rsp_data;
          end
          owner_d = OWN_NONE;
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: synchronous reset -- reset is just another input sampled at the clock edge.
    if (reset) begin
      state_q         <= ARB_IDLE;
      owner_q         <= OWN_NONE;
      streak_q        <= '0;
      i_req_ready_q   <= 1'b0;
      d_req_ready_q   <= 1'b0;
      i_rsp_valid_q   <= 1'b0;
      d_rsp_valid_q   <= 1'b0;
      i_rsp_data_q    <= '0;
      d_rsp_data_q    <= '0;
      m_req_valid_q   <= 1'b0;
      m_wr_en_q       <= 1'b0;
      m_size_q        <= MEM_BYTE;
      m_zero_extend_q <= 1'b0;
      m_addr_q        <= '0;
      m_wr_data_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop loads the pre-edge value of its inputs.
      state_q         <= state_d;
      owner_q         <= owner_d;
      streak_q        <= streak_d;
      i_req_ready_q   <= i_req_ready_d;
      d_req_ready_q   <= d_req_ready_d;
      i_rsp_valid_q   <= i_rsp_valid_d;
      d_rsp_valid_q   <= d_rsp_valid_d;
      i_rsp_data_q    <= i_rsp_data_d;
      d_rsp_data_q    <= d_rsp_data_d;
      m_req_valid_q   <= m_req_valid_d;
      m_wr_en_q       <= m_wr_en_d;
      m_size_q        <= m_size_d;
      m_zero_extend_q <= m_zero_extend_d;
      m_addr_q        <= m_addr_d;
      m_wr_data_q     <= m_wr_data_d;
    end
  end

  assign i_req_ready   = i_req_ready_q;
  assign d_req_ready   = d_req_ready_q;
  assign i_rsp_valid   = i_rsp_valid_q;
  assign d_rsp_valid   = d_rsp_valid_q;
  assign i_rsp_data    = i_rsp_data_q;
  assign d_rsp_data    = d_rsp_data_q;
  assign m_req_valid   = m_req_valid_q;
  assign m_wr_en       = m_wr_en_q;
  assign m_size        = m_size_q;
  assign m_zero_extend = m_zero_extend_q;
  assign m_addr        = m_addr_q;
  assign m_wr_data     = m_wr_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small memory responder that can
// stall, suppress its response, or inject a stray response strobe.
module tb_mem_port_arbiter;
  import risc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req_valid, i_req_ready, i_rsp_valid;
  logic [31:0] i_addr, i_rsp_data;
  logic        d_req_valid, d_req_ready, d_wr_en, d_zero_extend, d_rsp_valid;
  mem_size_t   d_size, m_size;
  logic [31:0] d_addr, d_wr_data, d_rsp_data;
  logic        m_req_valid, m_req_ready, m_wr_en, m_zero_extend, m_rsp_valid;
  logic [31:0] m_addr, m_wr_data, m_rsp_data;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          stall_left = 0;
  bit          mem_no_rsp = 1'b0;
  bit          inject_rsp = 1'b0;
  bit          accept_next = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_req_valid   (i_req_valid),
    .i_req_ready   (i_req_ready),
    .i_addr        (i_addr),
    .i_rsp_valid   (i_rsp_valid),
    .i_rsp_data    (i_rsp_data),
    .d_req_valid   (d_req_valid),
    .d_req_ready   (d_req_ready),
    .d_wr_en       (d_wr_en),
    .d_size        (d_size),
    .d_zero_extend (d_zero_extend),
    .d_addr        (d_addr),
    .d_wr_data     (d_wr_data),
    .d_rsp_valid   (d_rsp_valid),
    .d_rsp_data    (d_rsp_data),
    .m_req_valid   (m_req_valid),
    .m_req_ready   (m_req_ready),
    .m_wr_en       (m_wr_en),
    .m_size        (m_size),
    .m_zero_extend (m_zero_extend),
    .m_addr        (m_addr),
    .m_wr_data     (m_wr_data),
    .m_rsp_valid   (m_rsp_valid),
    .m_rsp_data    (m_rsp_data)
  );

  // Memory responder, updated mid-cycle: ready after stall_left valid cycles,
  // one response strobe the cycle after acceptance.
  initial begin
    m_req_ready = 1'b0;
    m_rsp_valid = 1'b0;
    m_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      m_rsp_valid = (accept_next && !mem_no_rsp) || inject_rsp;
      m_rsp_data  = m_rsp_valid ? mem_rdata : 32'h0;
      inject_rsp  = 1'b0;
      if (m_req_valid && stall_left > 0) begin
        stall_left  = stall_left - 1;
        m_req_ready = 1'b0;
      end else begin
        m_req_ready = (stall_left == 0);
      end
      accept_next = m_req_valid && m_req_ready;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // who: 1 = I, 2 = D, 3 = both, 0 = timeout
  task automatic wait_ready(output int who);
    who = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (i_req_ready || d_req_ready) begin
        who = (i_req_ready ? 1 : 0) + (d_req_ready ? 2 : 0);
        break;
      end
    end
  endtask

  task automatic wait_rsp(output int who, output logic [31:0] data);
    who  = 0;
    data = 32'h0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (i_rsp_valid || d_rsp_valid) begin
        who  = (i_rsp_valid ? 1 : 0) + (d_rsp_valid ? 2 : 0);
        data = i_rsp_valid ? i_rsp_data : d_rsp_data;
        break;
      end
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctl"}, 64'({i_req_ready, d_req_ready, i_rsp_valid, d_rsp_valid,
                              m_req_valid, m_wr_en, m_size, m_zero_extend}), 64'h0);
    check({tag, "_mreq"}, {m_addr, m_wr_data}, 64'h0);
    check({tag, "_rspd"}, {i_rsp_data, d_rsp_data}, 64'h0);
  endtask

  int          who;
  logic [31:0] rdata;
  int          exp_who[10]    = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
  int          exp_streak[10] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};
  int          cnt_mreq, cnt_irsp, cnt_drsp, cnt_irdy;

  initial begin
    reset = 1'b1;
    i_req_valid = 1'b0; i_addr = 32'h0;
    d_req_valid = 1'b0; d_wr_en = 1'b0; d_size = MEM_WORD; d_zero_extend = 1'b0;
    d_addr = 32'h0; d_wr_data = 32'h0;

    // 1: reset held three cycles with both requesting
    i_req_valid = 1'b1; i_addr = 32'h0000_0020;
    d_req_valid = 1'b1; d_addr = 32'h0000_0040;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_outputs_zero("rst_hold");
    end
    reset = 1'b0;
    tick();
    check("rst_first_grant", 64'({i_req_ready, d_req_ready}), 64'b01);
    check("rst_first_addr", 64'(m_addr), 64'h40);
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    mem_rdata = 32'h1111_2222;
    wait_rsp(who, rdata);
    check("rst_first_rsp_side", 64'(who), 64'd2);
    tick();

    // 2: lone fetch, zero-wait memory
    mem_rdata = 32'h0013_0093;
    i_req_valid = 1'b1; i_addr = 32'h0000_0010;
    tick();
    check("f_ready", 64'({i_req_ready, d_req_ready}), 64'b10);
    check("f_fields", {32'({m_wr_en, m_size, m_zero_extend}), m_addr},
          {32'({1'b0, MEM_WORD, 1'b0}), 32'h10});
    i_req_valid = 1'b0;
    tick();
    check("f_mreq_t2", 64'(m_req_valid), 64'd1);
    tick();
    check("f_mreq_t3", 64'(m_req_valid), 64'd0);
    tick();
    check("f_rsp_t4", 64'({i_rsp_valid, d_rsp_valid}), 64'b10);
    check("f_rsp_data", 64'(i_rsp_data), 64'h0013_0093);
    tick();
    check("f_rsp_t5", 64'({i_rsp_valid, d_rsp_valid}), 64'b00);

    // 3: both valid continuously, D streak limit 4
    i_req_valid = 1'b1; i_addr = 32'h0000_0100;
    d_req_valid = 1'b1; d_wr_en = 1'b0; d_size = MEM_WORD; d_addr = 32'h0000_0300;
    for (int g = 0; g < 10; g++) begin
      wait_ready(who);
      check($sformatf("streak_grant%0d", g), 64'(who), 64'(exp_who[g]));
      check($sformatf("streak_val%0d", g), 64'(dut.streak_q), 64'(exp_streak[g]));
    end
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    wait_rsp(who, rdata);
    check("streak_last_rsp", 64'(who), 64'd1);
    tick();

    // 4: byte store with five stall cycles
    stall_left = 5;
    d_req_valid = 1'b1; d_wr_en = 1'b1; d_size = MEM_BYTE; d_zero_extend = 1'b0;
    d_addr = 32'h0000_0104; d_wr_data = 32'h0000_00AB;
    tick();
    check("st_ready", 64'({i_req_ready, d_req_ready}), 64'b01);
    d_req_valid = 1'b0; d_wr_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("st_stall_ctl%0d", k), 64'({m_req_valid, m_wr_en, m_size, m_zero_extend}),
            64'({1'b1, 1'b1, MEM_BYTE, 1'b0}));
      check($sformatf("st_stall_fld%0d", k), {m_addr, m_wr_data}, {32'h104, 32'hAB});
    end
    tick();
    check("st_accept_cycle", 64'(m_req_valid), 64'd1);
    cnt_mreq = 0; cnt_irsp = 0; cnt_drsp = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      cnt_mreq += int'(m_req_valid);
      cnt_irsp += int'(i_rsp_valid);
      cnt_drsp += int'(d_rsp_valid);
    end
    check("st_no_second_mreq", 64'(cnt_mreq), 64'd0);
    check("st_rsp_counts", 64'({cnt_irsp[7:0], cnt_drsp[7:0]}), 64'h0001);

    // 5: reset while waiting for the response, stale response afterwards
    mem_no_rsp = 1'b1;
    i_req_valid = 1'b1; i_addr = 32'h0000_0200;
    tick();
    check("rw_ready", 64'(i_req_ready), 64'd1);
    i_req_valid = 1'b0;
    tick();
    tick();
    check("rw_in_wait", 64'(dut.state_q), 64'(ARB_WAIT));
    reset = 1'b1;
    tick();
    check_outputs_zero("rw_reset");
    reset = 1'b0;
    mem_no_rsp = 1'b0;
    tick();
    mem_rdata = 32'hBAD0_BAD0;
    inject_rsp = 1'b1;
    cnt_irsp = 0; cnt_drsp = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      cnt_irsp += int'(i_rsp_valid);
      cnt_drsp += int'(d_rsp_valid);
    end
    check("rw_no_rsp", 64'({cnt_irsp[7:0], cnt_drsp[7:0]}), 64'h0);
    check("rw_idle", 64'({dut.state_q, dut.owner_q}), 64'({ARB_IDLE, OWN_NONE}));

    // 6: spurious response in IDLE, then fetch withdrawing before it is granted
    inject_rsp = 1'b1;
    tick();
    tick();
    check("sp_ignored", 64'({i_rsp_valid, d_rsp_valid, dut.state_q}), 64'({2'b00, ARB_IDLE}));
    mem_rdata = 32'hDEAD_BEEF;
    d_req_valid = 1'b1; d_wr_en = 1'b0; d_size = MEM_HALF; d_zero_extend = 1'b1;
    d_addr = 32'h0000_0202;
    tick();
    check("dr_ready", 64'({i_req_ready, d_req_ready}), 64'b01);
    check("dr_fields", {32'({m_wr_en, m_size, m_zero_extend}), m_addr},
          {32'({1'b0, MEM_HALF, 1'b1}), 32'h202});
    d_req_valid = 1'b0;
    i_req_valid = 1'b1; i_addr = 32'h0000_0400;
    tick();
    i_req_valid = 1'b0;
    cnt_irdy = 0; cnt_irsp = 0; cnt_drsp = 0; rdata = 32'h0;
    for (int k = 0; k < 10; k++) begin
      tick();
      cnt_irdy += int'(i_req_ready);
      cnt_irsp += int'(i_rsp_valid);
      cnt_drsp += int'(d_rsp_valid);
      if (d_rsp_valid) rdata = d_rsp_data;
    end
    check("dr_i_never_granted", 64'({cnt_irdy[7:0], cnt_irsp[7:0]}), 64'h0);
    check("dr_d_rsp_once", 64'(cnt_drsp), 64'd1);
    check("dr_d_rsp_data", 64'(rdata), 64'hDEAD_BEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
